// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Contents:
//   state_t        - FSM state encoding (IDLE, CONV)
//   DEFAULT_N      - default binary input width
//   DEFAULT_DIGITS - default number of BCD output digits
//   digits_fit()   - elaboration-time check that 10^digits > 2^n
package bin2bcd_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam int DEFAULT_N      = 19;
  localparam int DEFAULT_DIGITS = 6;

  // True when DIGITS decimal digits can represent every N-bit value.
  // The loop exits early so that the power of ten never overflows 64 bits.
  // Input widths above 62 bits are rejected.
  function automatic bit digits_fit(input int n, input int d);
    longint unsigned p10;
    longint unsigned lim;
    if (n >= 63) return 1'b0;
    lim = 64'd1 << n;
    p10 = 64'd1;
    for (int i = 0; i < d; i++) begin
      if (p10 > lim) return 1'b1;
      p10 = p10 * 64'd10;
    end
    return (p10 > lim);
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
// Ports:
//   digit_i - scratch BCD digit before correction
//   digit_o - corrected digit
module bcd_add3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one input bit per clock,
// MSB first). A conversion takes N clocks from the accepting edge to the
// done pulse; a new start may be given in the done cycle.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-low reset
//   start - conversion request, sampled only while ready=1
//   bin   - unsigned binary value, sampled with start
//   ready - high while idle and able to accept start
//   bcd   - packed BCD result, digit 0 in bits [3:0]
//   blank - per-digit leading-zero flags (bit 0 is always 0)
//   done  - one-cycle pulse when bcd/blank carry a new result
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int N      = DEFAULT_N,
  parameter int DIGITS = DEFAULT_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [N-1:0]          bin,
  output logic                  ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank,
  output logic                  done
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(N + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

  if (!digits_fit(N, DIGITS)) begin : g_param_check
    $error("bin2bcd_seq: 10**DIGITS must exceed 2**N");
  end

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [N-1:0]      shift_q;
  logic [BW-1:0]     scratch_q;
  logic [BW-1:0]     corr;
  logic [BW-1:0]     scratch_d;
  logic [DIGITS-1:0] blank_d;
  logic [BW-1:0]     bcd_q;
  logic [DIGITS-1:0] blank_q;
  logic              done_q;
  logic              ready_q;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    bcd_add3 u_add3 (
      .digit_i (scratch_q[4*gi +: 4]),
      .digit_o (corr[4*gi +: 4])
    );
  end

  // Corrected scratch shifted left with the next input bit entering at bit 0.
  // The bit shifted out of the top digit is always zero when digits_fit holds.
  always_comb begin
    scratch_d    = corr << 1;
    scratch_d[0] = shift_q[N-1];
  end

  // blank[i] is set when digit i and every digit above it are zero.
  always_comb begin
    blank_d = '0;
    for (int i = 1; i < DIGITS; i++) begin
      blank_d[i] = 1'b1;
      for (int j = i; j < DIGITS; j++) begin
        if (scratch_d[4*j +: 4] != 4'd0) blank_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      blank_q   <= BLANK_RST;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            shift_q   <= bin;
            scratch_q <= '0;
            cnt_q     <= CW'(N);
            state_q   <= CONV;
            ready_q   <= 1'b0;
          end
        end
        CONV: begin
          scratch_q <= scratch_d;
          shift_q   <= shift_q << 1;
          cnt_q     <= cnt_q - CW'(1);
          // Last bit: publish the finished digits straight from scratch_d so
          // the outputs change only on completion.
          if (cnt_q == CW'(1)) begin
            bcd_q   <= scratch_d;
            blank_q <= blank_d;
            done_q  <= 1'b1;
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign bcd   = bcd_q;
  assign blank = blank_q;
  assign done  = done_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and random checks for bin2bcd_seq with N=19, DIGITS=6.
module tb_bin2bcd_seq;

  localparam int N      = 19;
  localparam int DIGITS = 6;

  logic                clk   = 1'b0;
  logic                reset = 1'b0;
  logic                start = 1'b0;
  logic [N-1:0]        bin   = '0;
  logic                ready;
  logic [4*DIGITS-1:0] bcd;
  logic [DIGITS-1:0]   blank;
  logic                done;

  int checks     = 0;
  int errors     = 0;
  int cycle      = 0;
  int done_total = 0;

  bin2bcd_seq #(.N(N), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .ready (ready),
    .bcd   (bcd),
    .blank (blank),
    .done  (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_total++;

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] model_bcd(input int v);
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [5:0] model_blank(input int v);
    logic [5:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 1; i < 6; i++) begin
      p = p * 10;
      r[i] = (v < p);
    end
    return r;
  endfunction

  // Issue one start, then wait (bounded) for done. lat = clocks from the
  // accepting edge to the done-high cycle, or -1 on timeout.
  task automatic convert(input int v, output int lat);
    start = 1'b1;
    bin   = N'(v);
    tick();
    start = 1'b0;
    lat   = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int t0;
    int low;
    int dn;
    int acc;
    int v;

    // Reset, with start held high to show reset wins.
    reset = 1'b0;
    start = 1'b1;
    bin   = 19'd77;
    tick();
    tick();
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_bcd", bcd, 0);
    check("rst_blank", blank, 6'b111110);
    start = 1'b0;
    reset = 1'b1;
    tick();
    check("idle_ready", ready, 1);

    // Zero
    convert(0, lat);
    check("zero_lat", lat, 19);
    check("zero_bcd", bcd, 24'h000000);
    check("zero_blank", blank, 6'b111110);
    check("zero_ready_at_done", ready, 1);
    tick();
    check("zero_done_width", done, 0);

    // Maximum value
    convert(524287, lat);
    check("max_lat", lat, 19);
    check("max_bcd", bcd, 24'h524287);
    check("max_blank", blank, 6'b000000);
    tick();

    // Back-to-back: second start in the done cycle
    convert(1234, lat);
    check("b2b_first_lat", lat, 19);
    check("b2b_first_bcd", bcd, 24'h001234);
    check("b2b_first_blank", blank, 6'b110000);
    t0 = cycle;
    convert(7, lat);
    check("b2b_done_spacing", cycle - t0, 20);
    check("b2b_second_bcd", bcd, 24'h000007);
    check("b2b_second_blank", blank, 6'b111110);
    tick();
    check("b2b_done_width", done, 0);

    // Starts during conversion are ignored; bin changes do not matter
    start = 1'b1;
    bin   = 19'd999;
    tick();
    bin   = 19'd5;
    start = 1'b0;
    low   = (ready === 1'b0) ? 1 : 0;
    dn    = done_total;
    for (int c = 1; c <= 45; c++) begin
      start = (c == 3 || c == 10);
      tick();
      if (ready === 1'b0) low++;
    end
    start = 1'b0;
    check("ign_ready_low", low, 19);
    check("ign_done_count", done_total - dn, 1);
    check("ign_bcd", bcd, 24'h000999);
    check("ign_blank", blank, 6'b111000);

    // Reset mid-conversion aborts; reset with start stays idle
    start = 1'b1;
    bin   = 19'd4321;
    tick();
    start = 1'b0;
    repeat (7) tick();
    dn    = done_total;
    reset = 1'b0;
    start = 1'b1;
    tick();
    check("abort_ready", ready, 1);
    check("abort_done", done, 0);
    check("abort_bcd", bcd, 24'h000000);
    check("abort_blank", blank, 6'b111110);
    reset = 1'b1;
    start = 1'b0;
    repeat (25) tick();
    check("abort_no_done", done_total - dn, 0);
    check("abort_ready_after", ready, 1);
    convert(4321, lat);
    check("abort_fresh_lat", lat, 19);
    check("abort_fresh_bcd", bcd, 24'h004321);
    check("abort_fresh_blank", blank, 6'b110000);
    tick();

    // Random values, mixing back-to-back and spaced starts
    dn  = done_total;
    acc = 0;
    for (int k = 0; k < 1000; k++) begin
      v = int'($urandom_range(0, 524287));
      convert(v, lat);
      acc++;
      check("rnd_lat", lat, 19);
      check("rnd_bcd", bcd, model_bcd(v));
      check("rnd_blank", blank, model_blank(v));
      if ($urandom_range(0, 1) == 1) tick();
    end
    repeat (3) tick();
    check("rnd_done_count", done_total - dn, acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter N, default 19, binary input width (matches divider result width).
REQ-002 SHALL have parameter DIGITS, default 6, number of BCD output digits; 10^DIGITS > 2^N required, elaboration error otherwise.
REQ-003 SHALL have port clk  input  1  rising-edge clock, sole clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  conversion request, sampled only while ready=1.
REQ-006 SHALL have port bin  input  N  unsigned binary value (divider quotient), sampled with start.
REQ-007 SHALL have port ready  output  1  high when idle and able to accept start.
REQ-008 SHALL have port bcd  output  4*DIGITS  packed BCD result, digit 0 in bits [3:0].
REQ-009 SHALL have port blank  output  DIGITS  per-digit leading-zero flag for seven-segment blanking.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking new bcd/blank.

Function
REQ-011 SHALL implement shift-add-3 (double-dabble) conversion, one bin bit per clock, MSB first.
REQ-012 SHALL use FSM states IDLE and CONV only; ready = (state==IDLE).
REQ-013 IDLE, start=1: latch bin into shift register, clear BCD scratch, load bit counter with N, go CONV.
REQ-014 IDLE, start=0: hold all state; done=0.
REQ-015 CONV, each cycle: every scratch digit >=5 gets +3, then scratch and shift register shift left one bit with shift-register MSB entering scratch bit 0; counter decrements.
REQ-016 CONV, final shift (counter==1): bcd and blank registers take final values, done=1 next cycle, state to IDLE.
REQ-017 Latency SHALL be exactly N clocks from start-accepting edge to done-high cycle; throughput one conversion per N+1 clocks.
REQ-018 start while in CONV SHALL be ignored; no queuing; bin changes during CONV SHALL not affect result.
REQ-019 start high during done cycle SHALL be accepted (ready is high then), giving back-to-back operation.
REQ-020 bcd and blank SHALL hold the last completed result until the next completion; scratch values never visible on outputs.
REQ-021 blank[i] SHALL be 1 iff digit i and all higher digits are zero, for i>=1; blank[0] SHALL always be 0.
REQ-022 Value 0 SHALL yield bcd all zero, blank = all ones except bit 0.
REQ-023 done SHALL be registered, high for exactly one cycle per accepted start.

Reset
REQ-024 On clk edge with reset=0: state=IDLE, counter=0, scratch=0, bcd=0, blank=all ones except bit 0, done=0, ready=1 next cycle.
REQ-025 Reset asserted mid-conversion SHALL abort it with no done pulse; reset dominates simultaneous start.

Structure
REQ-026 Shared package SHALL hold state encoding (IDLE, CONV) and default N/DIGITS constants.
REQ-027 Per-digit correction (>=5 then +3) SHALL be sub-module bcd_add3, instantiated DIGITS times.
REQ-028 All outputs SHALL come directly from flops; no combinational path from start/bin to outputs.

Verification
REQ-029 bin=0, start 1 cycle -> done after 19 clocks, bcd=0x000000, blank=6'b111110.
REQ-030 bin=524287 -> bcd=0x524287, blank=6'b000000, done exactly 19 clocks after start edge.
REQ-031 bin=1234 -> bcd=0x001234, blank=6'b110000; then bin=7 back-to-back, start in done cycle -> bcd=0x000007, blank=6'b111110, 20 clocks after first done.
REQ-032 start bin=999 then start pulses with bin=5 at clocks 3 and 10 -> single done, bcd=0x000999, ready low 19 clocks.
REQ-033 reset=0 at clock 8 of conversion of bin=4321 -> no done, bcd stays 0x000000, ready=1 after reset release; fresh start bin=4321 -> bcd=0x004321.
REQ-034 Random bin over 1000 conversions -> bcd equals scoreboard decimal digits, blank matches leading-zero rule, done count equals accepted starts.
